axis_dsp_stream_fork: RTL and testbench

AXIS_DSP_STREAM_FORK -- requirements
Module: axis_dsp_stream_fork

---
 rtl/axis_dsp_stream_fork.sv | 93 +++++++++
 tb/tb_axis_dsp_stream_fork.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dsp_stream_fork.sv
// One-to-four AXI-Stream broadcast with a shared beat register.
// Lane mask is frozen at frame start; lanes drain independently.
module axis_dsp_stream_fork #(
  parameter int DATA_WIDTH  = 48,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                     axis_aclk,
  input  logic                     axis_areset,
  input  logic [3:0]               fork_en_mask,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  output logic [4*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [3:0]               m_axis_tvalid,
  input  logic [3:0]               m_axis_tready,
  output logic [3:0]               m_axis_tlast,
  output logic [4*TUSER_WIDTH-1:0] m_axis_tuser,
  output logic [15:0]              frame_cnt,
  output logic                     in_frame
);

  typedef enum logic {
    IDLE,
    IN_FRAME
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              lane_mask_q, lane_mask_d;
  logic [3:0]              pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    last_q;
  logic [TUSER_WIDTH-1:0]  user_q;
  logic [15:0]             frame_cnt_q;
  logic [3:0]              eff_mask;
  logic                    accept;

  // Upstream may advance only when every pending lane drains this cycle
  assign s_axis_tready = ~axis_areset & (&(~pend_q | m_axis_tready));
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d     = state_q;
    lane_mask_d = lane_mask_q;
    eff_mask    = lane_mask_q;
    pend_d      = pend_q & ~m_axis_tready;
    unique case (state_q)
      IDLE: begin
        eff_mask = fork_en_mask;
        if (accept) begin
          lane_mask_d = fork_en_mask;
          if (!s_axis_tlast) state_d = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) pend_d = eff_mask;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q     <= IDLE;
      lane_mask_q <= '0;
      pend_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      user_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_mask_q <= lane_mask_d;
      pend_q      <= pend_d;
      if (accept) begin
        data_q <= s_axis_tdata;
        last_q <= s_axis_tlast;
        user_q <= s_axis_tuser;
        if (s_axis_tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = pend_q;
  assign m_axis_tdata  = {4{data_q}};
  assign m_axis_tlast  = {4{last_q}};
  assign m_axis_tuser  = {4{user_q}};
  assign frame_cnt     = frame_cnt_q;
  assign in_frame      = (state_q == IN_FRAME);

endmodule

// File: tb/tb_axis_dsp_stream_fork.sv
// Bench for axis_dsp_stream_fork: per-lane queue model plus
// directed scenarios and randomized traffic.
module tb_axis_dsp_stream_fork;

  localparam int DW = 48;
  localparam int UW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      mask;
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [UW-1:0]   s_tuser;
  logic [4*DW-1:0] m_tdata;
  logic [3:0]      m_tvalid;
  logic [3:0]      m_tready;
  logic [3:0]      m_tlast;
  logic [4*UW-1:0] m_tuser;
  logic [15:0]     fcnt_o;
  logic            infr_o;

  always #5 clk = ~clk;

  axis_dsp_stream_fork #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .axis_aclk    (clk),
    .axis_areset  (rst),
    .fork_en_mask (mask),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .frame_cnt    (fcnt_o),
    .in_frame     (infr_o)
  );

  int checks = 0;
  int errors = 0;
  int lane_cnt[4];
  int lowcnt = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: one FIFO of expected beats per lane
  logic [DW+UW:0] q[4][$];
  logic [3:0]     m_lmask = '0;
  bit             m_inf = 0;
  logic [15:0]    m_fcnt = '0;

  initial begin
    forever begin
      logic exp_rdy;
      logic [3:0] em;
      logic [DW+UW:0] got;
      @(negedge clk);
      exp_rdy = !rst;
      for (int i = 0; i < 4; i++)
        if (q[i].size() != 0 && !m_tready[i]) exp_rdy = 1'b0;
      chk("s_tready", 64'(s_tready), 64'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tvalid%0d", i), 64'(m_tvalid[i]),
            64'(q[i].size() != 0));
        if (q[i].size() != 0) begin
          got = {m_tlast[i], m_tuser[i*UW +: UW], m_tdata[i*DW +: DW]};
          chk($sformatf("beat%0d", i), 64'(got), 64'(q[i][0]));
        end
      end
      chk("in_frame", 64'(infr_o), 64'(m_inf));
      chk("frame_cnt", 64'(fcnt_o), 64'(m_fcnt));
      if (!rst && !s_tready) lowcnt++;
      if (rst) begin
        for (int i = 0; i < 4; i++) q[i].delete();
        m_lmask = '0;
        m_inf = 0;
        m_fcnt = '0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (q[i].size() != 0 && m_tready[i]) begin
            void'(q[i].pop_front());
            lane_cnt[i]++;
          end
        if (s_tvalid && exp_rdy) begin
          em = m_inf ? m_lmask : mask;
          for (int i = 0; i < 4; i++)
            if (em[i]) q[i].push_back({s_tlast, s_tuser, s_tdata});
          if (!m_inf) m_lmask = em;
          if (s_tlast) begin
            m_inf = 0;
            m_fcnt = m_fcnt + 16'd1;
          end else begin
            m_inf = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) m_tready = 4'($urandom);
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l,
                      input logic [UW-1:0] u);
    bit acc = 0;
    int n = 0;
    s_tdata = d;
    s_tlast = l;
    s_tuser = u;
    s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept d=%0h", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_deltas(input string name, input int base[4],
                            input int e0, input int e1, input int e2,
                            input int e3);
    chk({name, "_l0"}, 64'(lane_cnt[0] - base[0]), 64'(e0));
    chk({name, "_l1"}, 64'(lane_cnt[1] - base[1]), 64'(e1));
    chk({name, "_l2"}, 64'(lane_cnt[2] - base[2]), 64'(e2));
    chk({name, "_l3"}, 64'(lane_cnt[3] - base[3]), 64'(e3));
  endtask

  initial begin
    int base[4];
    int n;
    rst = 1'b1;
    mask = 4'hF;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = '0;
    m_tready = 4'hF;
    for (int i = 0; i < 4; i++) lane_cnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_tready", 64'(s_tready), 64'h0);
    chk("rst_fcnt", 64'(fcnt_o), 64'h0);
    chk("rst_inframe", 64'(infr_o), 64'h0);
    chk("rst_tdata", 64'(m_tdata[DW-1:0]), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Full-mask 8-beat frame with every lane ready
    base = lane_cnt;
    lowcnt = 0;
    for (int d = 1; d <= 8; d++) send(DW'(d), d == 8, 1'b0);
    idle(2);
    chk("f1_fcnt", 64'(fcnt_o), 64'd1);
    chk("f1_lowcnt", 64'(lowcnt), 64'd0);
    chk_deltas("f1", base, 8, 8, 8, 8);

    // Lane 2 stalls for three cycles on beat 5
    base = lane_cnt;
    lowcnt = 0;
    for (int d = 1; d <= 5; d++) send(DW'(d), 1'b0, 1'b1);
    m_tready = 4'b1011;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 m_tready = 4'hF;
      end
    join_none
    for (int d = 6; d <= 8; d++) send(DW'(d), d == 8, 1'b1);
    idle(4);
    chk("f2_lowcnt", 64'(lowcnt), 64'd3);
    chk("f2_fcnt", 64'(fcnt_o), 64'd2);
    chk_deltas("f2", base, 8, 8, 8, 8);

    // Mid-frame mask change is ignored until the next frame
    base = lane_cnt;
    mask = 4'b0101;
    send(48'h11, 1'b0, 1'b0);
    mask = 4'hF;
    for (int d = 2; d <= 4; d++) send(DW'(d + 16), d == 4, 1'b0);
    idle(2);
    chk_deltas("f3", base, 4, 0, 4, 0);
    base = lane_cnt;
    for (int d = 1; d <= 4; d++) send(DW'(d + 32), d == 4, 1'b1);
    idle(2);
    chk_deltas("f4", base, 4, 4, 4, 4);

    // Empty mask: beats are consumed and dropped
    base = lane_cnt;
    lowcnt = 0;
    mask = 4'h0;
    for (int d = 1; d <= 4; d++) send(DW'(d + 48), d == 4, 1'b0);
    idle(2);
    chk("f5_fcnt", 64'(fcnt_o), 64'd5);
    chk("f5_lowcnt", 64'(lowcnt), 64'd0);
    chk_deltas("f5", base, 0, 0, 0, 0);

    // Reset with lanes 1 and 3 still holding a beat
    mask = 4'b1010;
    m_tready = 4'h0;
    send(48'hABCDEF, 1'b0, 1'b1);
    idle(1);
    chk("pre_rst_tvalid", 64'(m_tvalid), 64'hA);
    base = lane_cnt;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("post_rst_inframe", 64'(infr_o), 64'h0);
    chk("post_rst_fcnt", 64'(fcnt_o), 64'h0);
    @(posedge clk);
    #1;
    m_tready = 4'hF;
    mask = 4'b0011;
    send(48'h1, 1'b0, 1'b0);
    mask = 4'hF;
    send(48'h2, 1'b1, 1'b0);
    idle(2);
    chk_deltas("f6", base, 2, 2, 0, 0);

    // Randomized traffic with random lane back-pressure
    ready_mode = 1;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 120) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send({$urandom, $urandom}, $urandom_range(0, 3) == 0,
           UW'($urandom));
    end
    ready_mode = 0;
    m_tready = 4'hF;
    idle(3);

    // frame_cnt wrap after 65536 single-beat frames
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    mask = 4'($urandom);
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    n = 0;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      s_tdata = DW'(c);
      @(negedge clk);
      if (s_tready) n++;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("wrap_pre", 64'(fcnt_o), 64'hFFFF);
    @(posedge clk);
    #1;
    send(48'h5A5A, 1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_post", 64'(fcnt_o), 64'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
